// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, arbiter FSM state type and frame timing helper.
package uart_pkg;

   localparam int FRAME_BITS = 10;

   typedef enum logic [1:0] {ARB, LOAD, WAIT} uart_arb_state_t;

   // One cycle beyond the serialiser's own frame so the line is idle before the next DV.
   function automatic int frame_cycles(input int clks_per_bit);
      return FRAME_BITS * clks_per_bit + 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational winner selection for the UART arbiter.
// Build option UART_ARB_FIXED_PRIO_EN: lowest requesting index wins and ptr is ignored.
module uart_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IDW-1:0]   gnt_idx,
   output logic             any
);

`ifdef UART_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      gnt_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) gnt_idx = IDW'(i);
      end
   end
`else
   // Walk offsets from farthest to nearest so the last hit is the closest one after ptr.
   always_comb begin
      gnt_idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % N_REQ]) gnt_idx = IDW'((int'(ptr) + i) % N_REQ);
      end
   end
`endif

   assign any        = |req;
   assign gnt_onehot = any ? (N_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_TX; times each frame itself and guards after reset.
// Build option UART_ARB_FIXED_PRIO_EN selects fixed priority in uart_rr_pick.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int N_REQ        = 4,
   parameter  int CLKS_PER_BIT = 10416,
   localparam int IDW          = $clog2(N_REQ)
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic [N_REQ-1:0]     i_REQ,
   input  logic [8*N_REQ-1:0]   i_BYTE,
   output logic [N_REQ-1:0]     o_GNT,
   output logic [IDW-1:0]       o_GNT_ID,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_BYTE,
   output logic                 o_BUSY
);

   localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT);
   localparam int CW           = $clog2(FRAME_CYCLES + 1);

   uart_arb_state_t  state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [IDW-1:0]   ptr;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] pick_onehot;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req        (i_REQ),
      .ptr        (ptr),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   // Reset enters WAIT with a full count: the uart_TX is not reset and may still be mid-frame.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state <= WAIT;
         cnt   <= CW'(FRAME_CYCLES);
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      o_BUSY    = 1'b1;
      o_TX_DV   = 1'b0;
      unique case (state)
         ARB: begin
            o_BUSY = 1'b0;
            if (pick_any) state_nxt = LOAD;
         end
         LOAD: begin
            o_TX_DV   = 1'b1;
            cnt_nxt   = CW'(FRAME_CYCLES);
            state_nxt = WAIT;
         end
         WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CW'(1)) state_nxt = ARB;
         end
         default: state_nxt = WAIT;
      endcase
   end

   // Winner, byte and pointer are captured on the ARB->LOAD edge and held until the next grant.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         ptr       <= IDW'(N_REQ - 1);
         gnt_q     <= '0;
         o_GNT_ID  <= '0;
         o_TX_BYTE <= '0;
      end else if (state == ARB && pick_any) begin
         ptr       <= pick_idx;
         gnt_q     <= pick_onehot;
         o_GNT_ID  <= pick_idx;
         o_TX_BYTE <= i_BYTE[{pick_idx, 3'b000} +: 8];
      end
   end

   assign o_GNT = (state == LOAD) ? gnt_q : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural serialiser + line decoder, scoreboard of grants and frames.
module tb_uart_tx_arbiter;

   localparam int N_REQ = 4;
   localparam int CPB   = 4;

   logic                 i_CLK = 1'b0;
   logic                 i_RST = 1'b1;
   logic [N_REQ-1:0]     i_REQ = '0;
   logic [8*N_REQ-1:0]   i_BYTE = '0;
   logic [N_REQ-1:0]     o_GNT;
   logic [1:0]           o_GNT_ID;
   logic                 o_TX_DV;
   logic [7:0]           o_TX_BYTE;
   logic                 o_BUSY;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_gnt = 0;
   int rst_cyc  = 0;

   typedef struct {
      int         idx;
      logic [7:0] b;
   } sb_t;

   sb_t        sb[$];
   logic [7:0] line_q[$];
   logic [8:0] dec_q[$];

   uart_tx_arbiter #(
      .N_REQ        (N_REQ),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_CLK     (i_CLK),
      .i_RST     (i_RST),
      .i_REQ     (i_REQ),
      .i_BYTE    (i_BYTE),
      .o_GNT     (o_GNT),
      .o_GNT_ID  (o_GNT_ID),
      .o_TX_DV   (o_TX_DV),
      .o_TX_BYTE (o_TX_BYTE),
      .o_BUSY    (o_BUSY)
   );

   always #5 i_CLK = ~i_CLK;
   always @(posedge i_CLK) cyc <= cyc + 1;

   // Stand-in for uart_TX: never reset, flags a DV that arrives mid-frame.
   logic       tx_line = 1'b1;
   int         tx_bit  = -1;
   int         tx_clk  = 0;
   logic [9:0] tx_sh   = '0;
   logic       overlap = 1'b0;

   always @(posedge i_CLK) begin
      if (tx_bit < 0) begin
         tx_line <= 1'b1;
         if (o_TX_DV === 1'b1) begin
            tx_sh  <= {1'b1, o_TX_BYTE, 1'b0};
            tx_bit <= 0;
            tx_clk <= 0;
         end
      end else begin
         tx_line <= tx_sh[tx_bit];
         if (o_TX_DV === 1'b1) overlap <= 1'b1;
         if (tx_clk == CPB - 1) begin
            tx_clk <= 0;
            tx_bit <= (tx_bit == 9) ? -1 : tx_bit + 1;
         end else begin
            tx_clk <= tx_clk + 1;
         end
      end
   end

   // Line decoder: mid-bit sampling, pushes {stop, data}.
   int         mon_cnt = -1;
   logic [8:0] mon_sh  = '0;

   always @(posedge i_CLK) begin
      if (mon_cnt < 0) begin
         if (tx_line === 1'b0) mon_cnt <= 1;
      end else begin
         if (mon_cnt % CPB == CPB / 2 && mon_cnt / CPB <= 8) mon_sh[mon_cnt / CPB] <= tx_line;
         if (mon_cnt == 9 * CPB + CPB / 2) begin
            dec_q.push_back({tx_line, mon_sh[8:1]});
            mon_cnt <= -1;
         end else begin
            mon_cnt <= mon_cnt + 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_byte(input int k, input logic [7:0] v);
      i_BYTE[8*k +: 8] = v;
   endtask

   task automatic push_exp(input int k, input logic [7:0] v);
      sb_t e;
      e.idx = k;
      e.b   = v;
      sb.push_back(e);
      line_q.push_back(v);
   endtask

   // Waits for the next o_TX_DV and scores it against the front of the scoreboard.
   task automatic expect_grant(input string tag, input int budget);
      sb_t e;
      int  n = 0;
      do begin
         @(negedge i_CLK);
         n++;
      end while (o_TX_DV !== 1'b1 && n < budget);
      if (o_TX_DV !== 1'b1) begin
         check({tag, "_timeout"}, 32'(o_TX_DV), 32'd1);
      end else if (sb.size() == 0) begin
         check({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_gnt"},  32'(o_GNT), 32'(1 << e.idx));
         check({tag, "_byte"}, 32'(o_TX_BYTE), 32'(e.b));
         check({tag, "_id"},   32'(o_GNT_ID), 32'(e.idx));
         last_gnt = cyc;
      end
   endtask

   task automatic expect_line(input string tag, input int budget);
      int         n = 0;
      logic [8:0] d;
      logic [7:0] x;
      while (dec_q.size() == 0 && n < budget) begin
         @(negedge i_CLK);
         n++;
      end
      if (dec_q.size() == 0 || line_q.size() == 0) begin
         check({tag, "_timeout"}, 32'(dec_q.size()), 32'd1);
      end else begin
         d = dec_q.pop_front();
         x = line_q.pop_front();
         check(tag, 32'(d), 32'({1'b1, x}));
      end
   endtask

   int         prev;
   int         k;
   int         dv_seen;
   int         order[5];
   logic [7:0] t3_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
      order = '{0, 0, 0, 0, 0};
`else
      order = '{0, 1, 2, 3, 0};
`endif

      // Test 1: reset guard with requester 0 already waiting.
      set_byte(0, 8'h5A);
      i_REQ = 4'b0001;
      i_RST = 1'b1;
      @(posedge i_CLK);
      #1 i_RST = 1'b0;
      @(negedge i_CLK);
      rst_cyc = cyc;
      check("rst_gnt",  32'(o_GNT), 32'd0);
      check("rst_dv",   32'(o_TX_DV), 32'd0);
      check("rst_byte", 32'(o_TX_BYTE), 32'd0);
      check("rst_id",   32'(o_GNT_ID), 32'd0);
      check("rst_busy", 32'(o_BUSY), 32'd1);
      push_exp(0, 8'h5A);
      expect_grant("t1", 100);
      check("t1_guard", 32'(cyc - rst_cyc), 32'd42);
      i_REQ = '0;
      expect_line("t1_line", 100);

      // Test 2: single request on index 2, busy window after grant.
      set_byte(2, 8'hA5);
      i_REQ = 4'b0100;
      push_exp(2, 8'hA5);
      expect_grant("t2", 100);
      i_REQ = '0;
      k = 0;
      while (o_BUSY === 1'b1 && k < 100) begin
         @(negedge i_CLK);
         k++;
      end
      check("t2_busy_len", 32'(k), 32'd42);
      expect_line("t2_line", 100);

      // Test 5: reset 15 cycles into a 3C frame; all four then request behind the guard.
      set_byte(3, 8'h3C);
      i_REQ = 4'b1000;
      push_exp(3, 8'h3C);
      expect_grant("t5", 100);
      for (int i = 0; i < 4; i++) set_byte(i, t3_bytes[i]);
      i_REQ = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(order[i], t3_bytes[order[i]]);
      repeat (15) @(posedge i_CLK);
      #1 i_RST = 1'b1;
      @(posedge i_CLK);
      #1 i_RST = 1'b0;
      @(negedge i_CLK);
      rst_cyc = cyc;
      check("t5_rst_busy", 32'(o_BUSY), 32'd1);
      check("t5_rst_id",   32'(o_GNT_ID), 32'd0);
      check("t5_rst_byte", 32'(o_TX_BYTE), 32'd0);
      expect_line("t5_line", 100);

      // Test 3: all four requesting, rotation and exact spacing.
      for (int i = 0; i < 5; i++) begin
         prev = last_gnt;
         expect_grant($sformatf("t3_g%0d", i), 100);
         if (i == 0) check("t5_guard_ok", 32'(cyc - rst_cyc >= 41), 32'd1);
         else        check($sformatf("t3_space%0d", i), 32'(last_gnt - prev), 32'd43);
      end

      // Test 4: during the WAIT after that grant, req1 and req3 rise; req1 drops before ARB.
      i_REQ = 4'b1010;
      set_byte(1, 8'h77);
      set_byte(3, 8'h88);
      repeat (10) @(negedge i_CLK);
      i_REQ = 4'b1000;
      push_exp(3, 8'h88);
      for (int i = 0; i < 5; i++) expect_line($sformatf("t3_line%0d", i), 100);
      prev = last_gnt;
      expect_grant("t4", 100);
      check("t4_space", 32'(last_gnt - prev), 32'd43);
      i_REQ = '0;
      dv_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_CLK);
         if (o_TX_DV === 1'b1) dv_seen++;
      end
      check("t4_quiet_dv", 32'(dv_seen), 32'd0);
      check("t4_id_held",  32'(o_GNT_ID), 32'd3);
      check("t4_idle",     32'(o_BUSY), 32'd0);
      expect_line("t4_line", 100);

`ifdef UART_ARB_FIXED_PRIO_EN
      // Test 6: fixed priority starves requester 3.
      i_REQ = 4'b1010;
      for (int i = 0; i < 3; i++) push_exp(1, 8'h77);
      for (int i = 0; i < 3; i++) expect_grant($sformatf("t6_g%0d", i), 100);
      i_REQ = '0;
      for (int i = 0; i < 3; i++) expect_line($sformatf("t6_line%0d", i), 100);
`endif

      check("sb_empty",   32'(sb.size()), 32'd0);
      check("line_empty", 32'(dec_q.size()), 32'd0);
      check("no_overlap", 32'(overlap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
